// File: rtl/beat_decode.sv
// Beat sequencer with run/step/halt control plus instruction register and
// opcode decoder. Produces one-hot beats t0..t7 and one-hot opcode lines.
module beat_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        step,
   input  logic        tset,
   input  logic        iir,
   input  logic [15:0] bus,
   output logic        t0,
   output logic        t1,
   output logic        t2,
   output logic        t3,
   output logic        t4,
   output logic        t5,
   output logic        t6,
   output logic        t7,
   output logic [15:0] cmd,
   output logic        _nop,
   output logic        _ld,
   output logic        _ln,
   output logic        _cp,
   output logic        _st,
   output logic        _shl,
   output logic        _add,
   output logic        _sub,
   output logic        _jz,
   output logic        _jb,
   output logic        _jmp,
   output logic        _xor,
   output logic        _or,
   output logic        _and,
   output logic        _shr,
   output logic        _not,
   output logic        _push,
   output logic        _pop,
   output logic        illegal,
   output logic        halted
);

   typedef enum logic [1:0] {
      S_HALT,
      S_RUN,
      S_STEP
   } state_t;

   state_t      state;
   logic [7:0]  beat;
   logic [7:0]  beat_next;
   logic        stop_pend;
   logic        boundary;
   logic [17:0] op_lines;

   // A boundary is the edge that lands on t0, by wrap from t7 or by tset.
   always_comb begin
      beat_next = tset ? 8'h01 : {beat[6:0], beat[7]};
      boundary  = (state != S_HALT) && (tset || beat[7]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_HALT;
         beat      <= 8'h01;
         stop_pend <= 1'b0;
         cmd       <= '0;
      end else begin
         if (iir)
            cmd <= bus;
         case (state)
            S_HALT: begin
               beat      <= 8'h01;
               stop_pend <= 1'b0;
               if (start)
                  state <= S_RUN;
               else if (step)
                  state <= S_STEP;
            end
            S_RUN: begin
               beat <= beat_next;
               if (boundary) begin
                  stop_pend <= 1'b0;
                  if (stop || stop_pend)
                     state <= S_HALT;
               end else if (stop) begin
                  stop_pend <= 1'b1;
               end
            end
            S_STEP: begin
               beat      <= beat_next;
               stop_pend <= 1'b0;
               if (boundary)
                  state <= S_HALT;
            end
            default: begin
               state     <= S_HALT;
               beat      <= 8'h01;
               stop_pend <= 1'b0;
            end
         endcase
      end
   end

   assign halted = (state == S_HALT);
   assign {t7, t6, t5, t4, t3, t2, t1, t0} = beat;

   // Unassigned opcodes fall back to nop so exactly one line stays high.
   always_comb begin
      op_lines = '0;
      illegal  = 1'b0;
      case (cmd[15:11])
         5'd0:  op_lines[0]  = 1'b1;
         5'd1:  op_lines[1]  = 1'b1;
         5'd2:  op_lines[2]  = 1'b1;
         5'd3:  op_lines[3]  = 1'b1;
         5'd4:  op_lines[4]  = 1'b1;
         5'd5:  op_lines[5]  = 1'b1;
         5'd6:  op_lines[6]  = 1'b1;
         5'd7:  op_lines[7]  = 1'b1;
         5'd8:  op_lines[8]  = 1'b1;
         5'd9:  op_lines[9]  = 1'b1;
         5'd10: op_lines[10] = 1'b1;
         5'd11: op_lines[11] = 1'b1;
         5'd12: op_lines[12] = 1'b1;
         5'd13: op_lines[13] = 1'b1;
         5'd14: op_lines[14] = 1'b1;
         5'd15: op_lines[15] = 1'b1;
         5'd16: op_lines[16] = 1'b1;
         5'd17: op_lines[17] = 1'b1;
         default: begin
            op_lines[0] = 1'b1;
            illegal     = 1'b1;
         end
      endcase
   end

   assign {_pop, _push, _not, _shr, _and, _or, _xor, _jmp, _jb,
           _jz, _sub, _add, _shl, _st, _cp, _ln, _ld, _nop} = op_lines;

endmodule

// File: tb/tb_beat_decode.sv
// Directed vector bench for beat_decode: a table of per-cycle stimulus and
// expected outputs, plus an opcode sweep and a bounded run sequence.
module tb_beat_decode;

   logic        clk = 1'b0;
   logic        reset, start, stop, step, tset, iir;
   logic [15:0] bus;
   logic        t0, t1, t2, t3, t4, t5, t6, t7;
   logic [15:0] cmd;
   logic        _nop, _ld, _ln, _cp, _st, _shl, _add, _sub, _jz;
   logic        _jb, _jmp, _xor, _or, _and, _shr, _not, _push, _pop;
   logic        illegal, halted;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   beat_decode dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
      .tset(tset), .iir(iir), .bus(bus),
      .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6), .t7(t7),
      .cmd(cmd),
      ._nop(_nop), ._ld(_ld), ._ln(_ln), ._cp(_cp), ._st(_st), ._shl(_shl),
      ._add(_add), ._sub(_sub), ._jz(_jz), ._jb(_jb), ._jmp(_jmp),
      ._xor(_xor), ._or(_or), ._and(_and), ._shr(_shr), ._not(_not),
      ._push(_push), ._pop(_pop),
      .illegal(illegal), .halted(halted)
   );

   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_RST   = 6'b100000;
   localparam logic [5:0] C_START = 6'b010000;
   localparam logic [5:0] C_STOP  = 6'b001000;
   localparam logic [5:0] C_STEP  = 6'b000100;
   localparam logic [5:0] C_TSET  = 6'b000010;
   localparam logic [5:0] C_IIR   = 6'b000001;

   typedef struct {
      logic [5:0]  ctl;
      logic [15:0] bus;
      int          t;
      logic        h;
      logic [15:0] cmd;
      int          op;
      logic        ill;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] ecmd;
   int          eop;
   logic        eill;

   task automatic row(input logic [5:0] c, input logic [15:0] b, input int t, input logic h);
      vec_t v;
      v.ctl = c; v.bus = b; v.t = t; v.h = h;
      v.cmd = ecmd; v.op = eop; v.ill = eill;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [5:0] c, input logic [15:0] b);
      {reset, start, stop, step, tset, iir} = c;
      bus = b;
   endtask

   task automatic check(input string name, input int t, input logic h,
                        input logic [15:0] c, input int op, input logic il);
      logic [7:0]  beats, ebeats;
      logic [17:0] ops, eops;
      beats  = {t7, t6, t5, t4, t3, t2, t1, t0};
      ebeats = 8'(1 << t);
      ops    = {_pop, _push, _not, _shr, _and, _or, _xor, _jmp, _jb,
                _jz, _sub, _add, _shl, _st, _cp, _ln, _ld, _nop};
      eops   = 18'(1 << op);
      n_checks += 5;
      if (beats !== ebeats) begin
         n_fail++;
         $display("FAIL %s beats got %b exp %b", name, beats, ebeats);
      end
      if (halted !== h) begin
         n_fail++;
         $display("FAIL %s halted got %b exp %b", name, halted, h);
      end
      if (cmd !== c) begin
         n_fail++;
         $display("FAIL %s cmd got %h exp %h", name, cmd, c);
      end
      if (ops !== eops) begin
         n_fail++;
         $display("FAIL %s opcodes got %b exp %b", name, ops, eops);
      end
      if (illegal !== il) begin
         n_fail++;
         $display("FAIL %s illegal got %b exp %b", name, illegal, il);
      end
   endtask

   task automatic cycle(input logic [5:0] c, input logic [15:0] b);
      @(negedge clk);
      drive(c, b);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned waited;
      drive(C_RST, 16'h0000);
      ecmd = 16'h0000; eop = 0; eill = 1'b0;

      // reset, then held HALT ignoring tset/stop
      row(C_RST, 16'h0000, 0, 1'b1);
      row(C_NONE, 16'hFFFF, 0, 1'b1);
      row(C_TSET, 16'hFFFF, 0, 1'b1);
      row(C_STOP, 16'hFFFF, 0, 1'b1);
      // start: halted drops, t0 held one more cycle, then two full wraps
      row(C_START, 16'h0000, 0, 1'b0);
      for (int k = 1; k < 8; k++) row(C_NONE, 16'h0000, k, 1'b0);
      row(C_NONE, 16'h0000, 0, 1'b0);
      for (int k = 1; k < 8; k++) row(C_NONE, 16'h0000, k, 1'b0);
      row(C_NONE, 16'h0000, 0, 1'b0);
      // stop at t3 finishes the instruction, then frozen at t0
      for (int k = 1; k < 4; k++) row(C_NONE, 16'h0000, k, 1'b0);
      row(C_STOP, 16'h0000, 4, 1'b0);
      for (int k = 5; k < 8; k++) row(C_NONE, 16'h0000, k, 1'b0);
      row(C_NONE, 16'h0000, 0, 1'b1);
      for (int k = 0; k < 10; k++) row(C_NONE, 16'h0000, 0, 1'b1);
      // load in HALT, then cmd holds against a changing bus
      ecmd = 16'h3102; eop = 6;
      row(C_IIR, 16'h3102, 0, 1'b1);
      row(C_NONE, 16'hFFFF, 0, 1'b1);
      // single step: one t1..t7 sequence then HALT
      row(C_STEP, 16'h0000, 0, 1'b0);
      for (int k = 1; k < 8; k++) row(C_NONE, 16'h0000, k, 1'b0);
      row(C_NONE, 16'h0000, 0, 1'b1);
      row(C_NONE, 16'h0000, 0, 1'b1);
      // start+step together runs past the boundary
      row(C_START | C_STEP, 16'h0000, 0, 1'b0);
      for (int k = 1; k < 8; k++) row(C_NONE, 16'h0000, k, 1'b0);
      for (int k = 0; k < 5; k++) row(C_NONE, 16'h0000, k, 1'b0);
      // tset at t4 restarts; then pending stop taken at a tset boundary
      row(C_TSET, 16'h0000, 0, 1'b0);
      row(C_NONE, 16'h0000, 1, 1'b0);
      row(C_STOP, 16'h0000, 2, 1'b0);
      row(C_NONE, 16'h0000, 3, 1'b0);
      row(C_NONE, 16'h0000, 4, 1'b0);
      row(C_TSET, 16'h0000, 0, 1'b1);
      row(C_NONE, 16'h0000, 0, 1'b1);
      // tset ends a step early
      row(C_STEP, 16'h0000, 0, 1'b0);
      row(C_NONE, 16'h0000, 1, 1'b0);
      row(C_TSET, 16'h0000, 0, 1'b1);
      // stop on the boundary edge itself
      row(C_START, 16'h0000, 0, 1'b0);
      for (int k = 1; k < 8; k++) row(C_NONE, 16'h0000, k, 1'b0);
      row(C_STOP, 16'h0000, 0, 1'b1);
      // loads while running, then reset at t5 overrides everything
      row(C_START, 16'h0000, 0, 1'b0);
      ecmd = 16'hA000; eop = 0; eill = 1'b1;
      row(C_IIR, 16'hA000, 1, 1'b0);
      ecmd = 16'h8800; eop = 17; eill = 1'b0;
      row(C_IIR, 16'h8800, 2, 1'b0);
      ecmd = 16'h3102; eop = 6;
      row(C_IIR, 16'h3102, 3, 1'b0);
      row(C_NONE, 16'h0000, 4, 1'b0);
      row(C_NONE, 16'h0000, 5, 1'b0);
      ecmd = 16'h0000; eop = 0;
      row(6'b111111, 16'hFFFF, 0, 1'b1);
      row(C_NONE, 16'h0000, 0, 1'b1);

      foreach (vecs[i]) begin
         cycle(vecs[i].ctl, vecs[i].bus);
         check($sformatf("vec%0d", i), vecs[i].t, vecs[i].h,
               vecs[i].cmd, vecs[i].op, vecs[i].ill);
      end

      // opcode sweep in HALT with a non-zero operand field
      for (int op = 0; op < 32; op++) begin
         logic [15:0] w;
         w = {5'(op), 11'h2A5};
         cycle(C_IIR, w);
         check($sformatf("op%0d", op), 0, 1'b1, w,
               (op < 18) ? op : 0, (op >= 18) ? 1'b1 : 1'b0);
      end

      // run and wait (bounded) for t7, then stop on that boundary
      cycle(C_START, 16'h0000);
      waited = 0;
      while (t7 !== 1'b1 && waited < 12) begin
         cycle(C_NONE, 16'h0000);
         waited++;
      end
      n_checks++;
      if (t7 !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_t7 got t7=%b after %0d cycles exp 1", t7, waited);
      end
      n_checks++;
      if (waited != 7) begin
         n_fail++;
         $display("FAIL t7_latency got %0d exp 7", waited);
      end
      cycle(C_STOP, 16'h0000);
      check("stop_at_t7", 0, 1'b1, 16'hFAA5, 0, 1'b1);

      @(negedge clk);
      drive(C_NONE, 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
